// File: rtl/swap_ctrl.sv
// Swap controller: exchanges two register-file entries (read A, read B, write A, write B).
// Define SWAP_VERIFY_EN to add a read-back verify pass that drives the sticky err flag.
module swap_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  ready,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  swap_count,
  output logic                  err,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address_w,
  output logic [ADDR_WIDTH-1:0] address_r,
  output logic [DATA_WIDTH-1:0] data_w,
  input  logic [DATA_WIDTH-1:0] data_r
);

`ifdef SWAP_VERIFY_EN
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE, VERIFY_A, VERIFY_B} state_t;
  logic err_reg;
`else
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_t;
`endif

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] la_reg, lb_reg;
  logic [DATA_WIDTH-1:0] tmp_a_reg, tmp_b_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  // Last driven write address/data, so the write bus holds steady while we=0.
  logic [ADDR_WIDTH-1:0] aw_hold_reg;
  logic [DATA_WIDTH-1:0] dw_hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      la_reg      <= '0;
      lb_reg      <= '0;
      tmp_a_reg   <= '0;
      tmp_b_reg   <= '0;
      count_reg   <= '0;
      aw_hold_reg <= '0;
      dw_hold_reg <= '0;
`ifdef SWAP_VERIFY_EN
      err_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            la_reg <= addr_a;
            lb_reg <= addr_b;
          end
        end
        RD_A: tmp_a_reg <= data_r;
        RD_B: tmp_b_reg <= data_r;
        WR_A, WR_B: begin
          aw_hold_reg <= address_w;
          dw_hold_reg <= data_w;
        end
        DONE: count_reg <= count_reg + 1'b1;
`ifdef SWAP_VERIFY_EN
        VERIFY_A: if (data_r != tmp_b_reg) err_reg <= 1'b1;
        VERIFY_B: if (data_r != tmp_a_reg) err_reg <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = RD_A;
      RD_A:     state_next = RD_B;
      RD_B:     state_next = WR_A;
      WR_A:     state_next = WR_B;
`ifdef SWAP_VERIFY_EN
      WR_B:     state_next = VERIFY_A;
      VERIFY_A: state_next = VERIFY_B;
      VERIFY_B: state_next = DONE;
`else
      WR_B:     state_next = DONE;
`endif
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    address_w = aw_hold_reg;
    data_w    = dw_hold_reg;
    address_r = la_reg;
    case (state_reg)
      IDLE: ready = 1'b1;
      RD_B: address_r = lb_reg;
      WR_A: begin
        we        = 1'b1;
        address_w = la_reg;
        data_w    = tmp_b_reg;
      end
      WR_B: begin
        we        = 1'b1;
        address_w = lb_reg;
        data_w    = tmp_a_reg;
      end
`ifdef SWAP_VERIFY_EN
      VERIFY_B: address_r = lb_reg;
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign swap_count = count_reg;
`ifdef SWAP_VERIFY_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_swap_ctrl.sv
// Self-checking bench for swap_ctrl: behavioural register file plus a swap-level reference model.
module tb_swap_ctrl;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int CW = 4;  // narrow counter so wrap-around is reachable quickly
`ifdef SWAP_VERIFY_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic          ready, done, err, we;
  logic [CW-1:0] swap_count;
  logic [AW-1:0] address_w, address_r;
  logic [DW-1:0] data_w, data_r;

  swap_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_a(addr_a), .addr_b(addr_b),
    .ready(ready), .done(done), .swap_count(swap_count), .err(err),
    .we(we), .address_w(address_w), .address_r(address_r),
    .data_w(data_w), .data_r(data_r)
  );

  always #5 clk = ~clk;

  // Register file environment: one write port, asynchronous read.
  logic [DW-1:0] mem [0:127];
  logic          fill_en = 1'b0, poke_en = 1'b0, corrupt_en = 1'b0;
  logic [AW-1:0] poke_addr = '0, corrupt_addr = '0;
  logic [DW-1:0] poke_data = '0;
  assign data_r = mem[address_r];
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (we) begin
      mem[address_w] <= (corrupt_en && address_w == corrupt_addr) ? '0 : data_w;
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:127];
  int model_count = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Per-cycle observations of the most recent swap (index = cycles after accepting edge)
  logic [9:0]    obs_we, obs_done, obs_ready, obs_err;
  logic [AW-1:0] obs_ar [0:9];
  logic [AW-1:0] obs_aw [0:9];
  logic [DW-1:0] obs_dw [0:9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    step();
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic void model_swap(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [DW-1:0] t;
    t = ref_mem[a];
    ref_mem[a] = ref_mem[b];
    ref_mem[b] = t;
    model_count = (model_count + 1) % (1 << CW);
  endfunction

  task automatic run_swap(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int waited = 0;
    while (!ready && waited < 20) begin step(); waited++; end
    n_checks++;
    if (ready !== 1'b1) begin $display("FAIL swap_wait_ready ready=%b required 1", ready); n_fail++; end
    obs_we = '0; obs_done = '0; obs_ready = '0; obs_err = '0;
    addr_a = a; addr_b = b; start = 1'b1;
    step();
    start = 1'b0;
    addr_a = AW'($urandom); addr_b = AW'($urandom);
    for (int c = 1; c <= LAT + 1; c++) begin
      obs_we[c] = we; obs_done[c] = done; obs_ready[c] = ready; obs_err[c] = err;
      obs_ar[c] = address_r; obs_aw[c] = address_w; obs_dw[c] = data_w;
      if (c <= LAT) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fill_en = 1'b1;
    step(); step();
    rst = 1'b0; fill_en = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 7 + 3);
    model_count = 0;
    n_checks++;
    if ({ready, done, we, err} !== 4'b1000) begin
      $display("FAIL reset_flags ready/done/we/err=%b required 1000", {ready, done, we, err}); n_fail++;
    end
    n_checks++;
    if ({address_w, address_r, data_w} !== '0) begin
      $display("FAIL reset_buses aw=%h ar=%h dw=%h required 0", address_w, address_r, data_w); n_fail++;
    end
    n_checks++;
    if (swap_count !== '0) begin $display("FAIL reset_count count=%0d required 0", swap_count); n_fail++; end
  endtask

  task automatic test_basic();
    poke(7'd3, 8'h11);
    poke(7'd9, 8'hA5);
    run_swap(7'd3, 7'd9);
    model_swap(7'd3, 7'd9);
    n_checks++;
    if (obs_we !== 10'b0000011000) begin $display("FAIL basic_we_cycles got=%b required 0000011000", obs_we); n_fail++; end
    n_checks++;
    if (obs_done !== 10'(1 << LAT)) begin $display("FAIL basic_done_cycle got=%b required %b", obs_done, 10'(1 << LAT)); n_fail++; end
    n_checks++;
    if (obs_ready !== 10'(1 << (LAT + 1))) begin $display("FAIL basic_ready got=%b required %b", obs_ready, 10'(1 << (LAT + 1))); n_fail++; end
    n_checks++;
    if ({obs_ar[1], obs_ar[2]} !== {7'd3, 7'd9}) begin $display("FAIL basic_read_addr got=%h,%h required 03,09", obs_ar[1], obs_ar[2]); n_fail++; end
    n_checks++;
    if ({obs_aw[3], obs_dw[3], obs_aw[4], obs_dw[4]} !== {7'd3, 8'hA5, 7'd9, 8'h11}) begin
      $display("FAIL basic_writes got=(%h,%h)(%h,%h) required (03,a5)(09,11)", obs_aw[3], obs_dw[3], obs_aw[4], obs_dw[4]); n_fail++;
    end
    n_checks++;
    if ({mem[3], mem[9]} !== {8'hA5, 8'h11}) begin $display("FAIL basic_mem got=%h,%h required a5,11", mem[3], mem[9]); n_fail++; end
    n_checks++;
    if (swap_count !== CW'(model_count)) begin $display("FAIL basic_count got=%0d required %0d", swap_count, model_count); n_fail++; end
  endtask

  task automatic test_same_addr();
    poke(7'h7F, 8'h3C);
    run_swap(7'h7F, 7'h7F);
    model_swap(7'h7F, 7'h7F);
    n_checks++;
    if ({obs_aw[3], obs_dw[3], obs_aw[4], obs_dw[4]} !== {7'h7F, 8'h3C, 7'h7F, 8'h3C}) begin
      $display("FAIL same_writes got=(%h,%h)(%h,%h) required (7f,3c)(7f,3c)", obs_aw[3], obs_dw[3], obs_aw[4], obs_dw[4]); n_fail++;
    end
    n_checks++;
    if (mem[127] !== 8'h3C || obs_done !== 10'(1 << LAT)) begin
      $display("FAIL same_mem_done mem=%h done=%b required 3c,%b", mem[127], obs_done, 10'(1 << LAT)); n_fail++;
    end
    n_checks++;
    if (swap_count !== CW'(model_count)) begin $display("FAIL same_count got=%0d required %0d", swap_count, model_count); n_fail++; end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] a, b;
      logic [DW-1:0] va, vb;
      a = AW'($urandom); b = AW'($urandom_range(0, 127));
      va = ref_mem[a]; vb = ref_mem[b];
      run_swap(a, b);
      model_swap(a, b);
      n_checks++;
      if ({obs_aw[3], obs_dw[3], obs_aw[4], obs_dw[4]} !== {a, vb, b, va}) begin
        $display("FAIL rand_writes a=%h b=%h got=(%h,%h)(%h,%h) required (%h,%h)(%h,%h)",
                 a, b, obs_aw[3], obs_dw[3], obs_aw[4], obs_dw[4], a, vb, b, va); n_fail++;
      end
      n_checks++;
      if (mem[a] !== ref_mem[a] || mem[b] !== ref_mem[b]) begin
        $display("FAIL rand_mem a=%h b=%h got=%h,%h required %h,%h", a, b, mem[a], mem[b], ref_mem[a], ref_mem[b]); n_fail++;
      end
      n_checks++;
      if (swap_count !== CW'(model_count) || obs_err !== '0 || obs_done !== 10'(1 << LAT)) begin
        $display("FAIL rand_count_err_done count=%0d err=%b done=%b required %0d,0,%b",
                 swap_count, obs_err, obs_done, model_count, 10'(1 << LAT)); n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, violations = 0, exp_swaps;
    logic prev_done = 1'b0;
    exp_swaps = (20 + LAT) / (LAT + 1);
    addr_a = 7'd40; addr_b = 7'd41; start = 1'b1;
    for (int c = 0; c < 20 + LAT + 2; c++) begin
      if (c == 20) start = 1'b0;
      step();
      if (prev_done && !ready) violations++;
      if (done) dones++;
      prev_done = done;
    end
    for (int k = 0; k < exp_swaps; k++) model_swap(7'd40, 7'd41);
    n_checks++;
    if (dones != exp_swaps) begin $display("FAIL b2b_done_count got=%0d required %0d", dones, exp_swaps); n_fail++; end
    n_checks++;
    if (violations != 0) begin $display("FAIL b2b_idle_gap violations=%0d required 0", violations); n_fail++; end
    n_checks++;
    if (swap_count !== CW'(model_count) || mem[40] !== ref_mem[40] || mem[41] !== ref_mem[41]) begin
      $display("FAIL b2b_state count=%0d mem=%h,%h required %0d,%h,%h", swap_count, mem[40], mem[41],
               model_count, ref_mem[40], ref_mem[41]); n_fail++;
    end
  endtask

  task automatic test_reset_mid_write();
    int stray = 0;
    logic [DW-1:0] vb_old, va_old;
    va_old = ref_mem[20]; vb_old = ref_mem[21];
    addr_a = 7'd20; addr_b = 7'd21; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    n_checks++;
    if (we !== 1'b1 || address_w !== 7'd20) begin $display("FAIL rstw_in_wr_a we=%b aw=%h required 1,14", we, address_w); n_fail++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_mem[20] = vb_old;
    model_count = 0;
    n_checks++;
    if ({we, ready, done} !== 3'b010 || swap_count !== '0) begin
      $display("FAIL rstw_after we/ready/done=%b count=%0d required 010,0", {we, ready, done}, swap_count); n_fail++;
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (we || done) stray++;
    end
    n_checks++;
    if (stray != 0) begin $display("FAIL rstw_stray_activity got=%0d required 0", stray); n_fail++; end
    n_checks++;
    if (mem[20] !== vb_old || mem[21] !== vb_old) begin
      $display("FAIL rstw_half_swap mem=%h,%h required %h,%h (old a %h)", mem[20], mem[21], vb_old, vb_old, va_old); n_fail++;
    end
  endtask

  task automatic test_count_wrap();
    int guard = 0;
    while (model_count != (1 << CW) - 1 && guard < 20) begin
      logic [AW-1:0] a, b;
      a = AW'($urandom); b = AW'($urandom);
      run_swap(a, b);
      model_swap(a, b);
      guard++;
    end
    n_checks++;
    if (swap_count !== {CW{1'b1}}) begin $display("FAIL wrap_all_ones got=%0d required %0d", swap_count, (1 << CW) - 1); n_fail++; end
    run_swap(7'd50, 7'd60);
    model_swap(7'd50, 7'd60);
    n_checks++;
    if (swap_count !== '0 || model_count != 0) begin $display("FAIL wrap_to_zero got=%0d required 0", swap_count); n_fail++; end
  endtask

`ifdef SWAP_VERIFY_EN
  task automatic test_verify();
    poke(7'd3, 8'h11);
    poke(7'd9, 8'hA5);
    corrupt_en = 1'b1; corrupt_addr = 7'd9;
    run_swap(7'd3, 7'd9);
    corrupt_en = 1'b0;
    ref_mem[3] = 8'hA5; ref_mem[9] = 8'h00;
    model_count = (model_count + 1) % (1 << CW);
    n_checks++;
    if (obs_err[6] !== 1'b0 || obs_err[7] !== 1'b1) begin
      $display("FAIL verify_err_timing c6=%b c7=%b required 0,1", obs_err[6], obs_err[7]); n_fail++;
    end
    n_checks++;
    if (obs_done !== 10'(1 << 7) || mem[9] !== 8'h00 || swap_count !== CW'(model_count)) begin
      $display("FAIL verify_done done=%b mem9=%h count=%0d required %b,00,%0d", obs_done, mem[9], swap_count, 10'(1 << 7), model_count); n_fail++;
    end
    for (int c = 0; c < 5; c++) step();
    n_checks++;
    if (err !== 1'b1) begin $display("FAIL verify_sticky err=%b required 1", err); n_fail++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_count = 0;
    n_checks++;
    if (err !== 1'b0) begin $display("FAIL verify_clear err=%b required 0", err); n_fail++; end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_same_addr();
    test_random(6);
    test_back_to_back();
    test_reset_mid_write();
    test_count_wrap();
`ifdef SWAP_VERIFY_EN
    test_verify();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/swap_ctrl.md
Name: swap_ctrl

Overview:
- FSM initiator that drives the team's single-write-port / single-async-read-port register file to exchange the contents of two addresses.
- Sits between a host request interface (start/ready/done) and the register file's we, address_w, address_r, data_w, data_r pins.
- Performs read A, read B, write A, write B.
- Counts completed swaps.

Parameters:
ADDR_WIDTH, 7, register-file address width; must match the attached register file.
DATA_WIDTH, 8, register-file data width; must match the attached register file.
CNT_WIDTH, 16, width of the completed-swap counter.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  host request; accepted only when ready=1.
addr_a  input  ADDR_WIDTH  first swap address; sampled on the accepting edge.
addr_b  input  ADDR_WIDTH  second swap address; sampled on the accepting edge.
ready  output  1  high only in IDLE.
done  output  1  one-cycle pulse when the swap completes.
swap_count  output  CNT_WIDTH  number of completed swaps; wraps modulo 2^CNT_WIDTH.
err  output  1  sticky verify-mismatch flag; see Optional Feature.
we  output  1  register-file write enable.
address_w  output  ADDR_WIDTH  register-file write address.
address_r  output  ADDR_WIDTH  register-file read address.
data_w  output  DATA_WIDTH  register-file write data.
data_r  input  DATA_WIDTH  register-file asynchronous read data; valid in the same cycle as address_r.

Behaviour:
Interface rules:
- One clock, clk.
- Reset is synchronous and active-high on rst.
- rst=1 at a rising edge has priority over all other inputs:
  - state to IDLE; latched addresses and temporaries to 0; swap_count to 0; err to 0.
  - After that edge: ready=1, done=0, we=0, address_w=0, address_r=0, data_w=0.
- All outputs are decoded from registered state and registered latches only; no combinational path from start or data_r to any output.

FSM states: IDLE, RD_A, RD_B, WR_A, WR_B, DONE (plus VERIFY_A, VERIFY_B when the optional feature is enabled).

State actions and transitions:
- IDLE:
  - ready=1, we=0.
  - If start=1: latch addr_a into la, addr_b into lb; go to RD_A. Otherwise stay.
- RD_A:
  - address_r=la.
  - At the edge, capture data_r into tmp_a; go to RD_B.
- RD_B:
  - address_r=lb.
  - At the edge, capture data_r into tmp_b; go to WR_A.
- WR_A:
  - we=1, address_w=la, data_w=tmp_b.
  - The register file commits at the closing edge; go to WR_B.
- WR_B:
  - we=1, address_w=lb, data_w=tmp_a.
  - Go to DONE, or to VERIFY_A when the optional feature is enabled.
- DONE:
  - done=1 for exactly this cycle.
  - swap_count increments at the closing edge; go to IDLE.
  - ready stays 0 in DONE, so back-to-back starts are separated by at least one IDLE cycle.

Default outputs:
- we=0 outside WR_A/WR_B.
- address_w and data_w hold their last values when we=0.
- address_r=la in IDLE.

Timing:
- Accepting edge = cycle 0; done is high in cycle 5.
- First write commits at the end of cycle 3; second write commits at the end of cycle 4.

Boundary conditions:
- start while ready=0 is ignored; it is neither queued nor latched.
- addr_a==addr_b: the full sequence runs, memory content is unchanged, done pulses, and swap_count increments.
- addr_a/addr_b changing after acceptance has no effect; latched values are used.
- Reset during WR_A: that write still commits at the reset edge; none afterward. After reset no further write occurs, so memory may be left half-swapped. This is permitted; the host must reissue the swap.
- swap_count at all-ones wraps to 0 on the next completion.

Optional Feature:
Macro: SWAP_VERIFY_EN

With the macro defined:
- WR_B goes to VERIFY_A instead of DONE.
- VERIFY_A: address_r=la; compare data_r with tmp_b.
- VERIFY_B: address_r=lb; compare data_r with tmp_a.
- Any mismatch sets err=1 at that edge; err stays set until rst.
- VERIFY_B goes to DONE, so done arrives in cycle 7.
- swap_count increments regardless of the compare result.

Without the macro:
- No verify states exist; err is tied to 0; done arrives in cycle 5.

Test Plan:
1. Preload mem[3]=0x11, mem[9]=0xA5; start with addr_a=3, addr_b=9 -> ready falls next cycle; we pulses in cycles 3 and 4 with (3,0xA5) then (9,0x11); done in cycle 5 (7 with SWAP_VERIFY_EN); mem[3]=0xA5, mem[9]=0x11; swap_count=1.
2. addr_a=addr_b=0x7F with mem[0x7F]=0x3C -> two writes of 0x3C to 0x7F; memory unchanged; done pulses; swap_count increments.
3. start held high continuously for 20 cycles -> swaps start only from IDLE; the last done pulse is followed by at least one ready=1 cycle before the next write sequence; swap_count counts completions only.
4. Assert rst in the WR_A cycle -> we=0 and ready=1 from the cycle after the reset edge; mem[addr_a] holds the new value, mem[addr_b] holds the old value; swap_count=0; no done pulse.
5. Force swap_count to 0xFFFF (CNT_WIDTH=16) and complete one swap -> swap_count reads 0x0000.
6. With SWAP_VERIFY_EN, corrupt the register-file write path so mem[addr_b] stores 0x00 instead of 0x11 -> err=1 from the VERIFY_B edge onward, done still pulses in cycle 7, err clears only on rst.
